// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A 1-bit operand still needs a 1-bit counter, which $clog2(1) would not give.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_mux.sv
// 1-bit full subtractor cell, D = A - B - Bin, with the borrow formed by a 2:1 mux
// steered by A^B.
module full_subtractor_mux (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic prop;

  // When A and B differ the borrow is simply B; when equal the incoming borrow ripples.
  assign prop = A ^ B;
  assign D    = prop ? ~Bin : Bin;
  assign Bout = prop ? B : Bin;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) through one shared cell.
// Optional signed-overflow output enabled by defining SERSUB_OVF_EN.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_nxt;
  logic [WIDTH:0]   diff_cat;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor_mux u_cell (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (borrow),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));
  assign diff_cat = {cell_d, diff_sh};
  assign diff_nxt = diff_cat[WIDTH:1];

  // Operand/result shift registers: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= diff_nxt;
    end
  end

  // Control FSM, borrow/count and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      borrow <= 1'b0;
      count  <= '0;
`ifdef SERSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          borrow <= cell_bout;
          count  <= count + 1'b1;
          if (last_bit) begin
            diff  <= diff_nxt;
            bout  <= cell_bout;
`ifdef SERSUB_OVF_EN
            // borrow still holds the borrow into the MSB on this edge
            ovf   <= borrow ^ cell_bout;
`endif
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: scoreboarded WIDTH=8 directed
// jobs plus an exhaustive WIDTH=4 sweep; ovf checks when SERSUB_OVF_EN is defined.
module tb_serial_subtractor_ctrl;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp8_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;
`ifdef SERSUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt8 = 0;
  exp8_t      q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b);
    exp8_t e;
    e.diff = a - b;
    e.bout = (a < b);
    e.ovf  = (a[7] != b[7]) && (e.diff[7] != a[7]);
    return e;
  endfunction

  // Drive a one-cycle start from an IDLE DUT; returns the accept-edge cycle index.
  task automatic start_job8(input logic [7:0] a, input logic [7:0] b, input bit push,
                            output int acc);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    if (push) q8.push_back(model8(a, b));
    tick(1);
    start8 = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done8(input int budget, output int at_cyc);
    int k = 0;
    while (!done8 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done8) check("done8_timeout", done8, 1);
    at_cyc = cyc;
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      done_cnt8++;
      check("sb8_nonempty", (q8.size() != 0), 1);
      if (q8.size() != 0) begin
        exp8_t e;
        e = q8.pop_front();
        check("diff8", diff8, e.diff);
        check("bout8", bout8, e.bout);
`ifdef SERSUB_OVF_EN
        check("ovf8", ovf8, e.ovf);
`endif
      end
    end
    if (!rst && done4) begin
      check("sb4_nonempty", (q4.size() != 0), 1);
      if (q4.size() != 0) check("exh4", {bout4, diff4}, q4.pop_front());
    end
  end

  initial begin
    int acc, dc, base, seen, tprev, k;
    logic [7:0] va [3];
    logic [7:0] vb [3];

    // reset state
    tick(3);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_bout", bout8, 0);
    rst = 1'b0;
    tick(1);

    // basic job, latency and busy profile
    start_job8(8'd200, 8'd55, 1'b1, acc);
    check("busy_run", busy8, 1);
    wait_done8(20, dc);
    check("latency", dc - acc, 8);
    check("busy_done", busy8, 1);
    tick(1);
    check("busy_idle", busy8, 0);
    check("done_pulse", done8, 0);
    check("diff_held", diff8, 8'd145);

    // more operand patterns
    va[0] = 8'd5;   vb[0] = 8'd10;
    va[1] = 8'd0;   vb[1] = 8'd0;
    va[2] = 8'd255; vb[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      start_job8(va[i], vb[i], 1'b1, acc);
      wait_done8(20, dc);
      tick(1);
    end

    // start during RUN is ignored; operand changes after accept have no effect
    base = done_cnt8;
    start_job8(8'd100, 8'd30, 1'b1, acc);
    tick(2);
    a8 = 8'd1;
    b8 = 8'd1;
    start8 = 1'b1;
    tick(1);
    start8 = 1'b0;
    wait_done8(20, dc);
    tick(12);
    check("single_done", done_cnt8 - base, 1);
    check("diff_stable", diff8, 8'd70);

    // start held high: back-to-back accepts every WIDTH+2 cycles
    for (int i = 0; i < 3; i++) q8.push_back(model8(8'd9, 8'd4));
    a8 = 8'd9;
    b8 = 8'd4;
    start8 = 1'b1;
    seen = 0;
    tprev = 0;
    k = 0;
    while (seen < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (done8) begin
        if (seen > 0) check("done_spacing", cyc - tprev, 10);
        tprev = cyc;
        seen++;
      end
    end
    start8 = 1'b0;
    check("b2b_count", seen, 3);
    tick(2);

    // reset mid-operation discards the job
    base = done_cnt8;
    start_job8(8'd77, 8'd11, 1'b0, acc);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", busy8, 0);
    check("midrst_diff", diff8, 0);
    check("midrst_bout", bout8, 0);
    check("midrst_done", done8, 0);
    tick(15);
    check("midrst_nodone", done_cnt8 - base, 0);

    // rst and start together: rst wins
    rst = 1'b1;
    a8 = 8'd3;
    b8 = 8'd1;
    start8 = 1'b1;
    tick(1);
    rst = 1'b0;
    start8 = 1'b0;
    check("rst_start_busy", busy8, 0);
    tick(12);
    check("rst_start_nodone", done_cnt8 - base, 0);

`ifdef SERSUB_OVF_EN
    start_job8(8'h80, 8'h01, 1'b1, acc);
    wait_done8(20, dc);
    tick(1);
    check("ovf_set", ovf8, 1);
    start_job8(8'h10, 8'h01, 1'b1, acc);
    wait_done8(20, dc);
    tick(1);
    check("ovf_clr", ovf8, 0);
`endif

    // exhaustive sweep on the 4-bit instance
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        logic [4:0] ea, eb;
        ea = {1'b0, 4'(ia)};
        eb = {1'b0, 4'(ib)};
        a4 = 4'(ia);
        b4 = 4'(ib);
        start4 = 1'b1;
        q4.push_back(ea - eb);
        tick(1);
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 20) begin
          @(negedge clk);
          k++;
        end
        if (!done4) check("done4_timeout", done4, 1);
        tick(1);
      end
    end

    tick(2);
    check("sb8_drained", q8.size(), 0);
    check("sb4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
